// File: rtl/btn_evt_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_evt_pkg;

    localparam int unsigned LONG_PRESS_CYCLES_DEF = 20;
    localparam int unsigned DOUBLE_CLICK_GAP_DEF  = 10;
    localparam int unsigned CNT_W_DEF             = 16;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } btn_state_t;

    // One bit per decoded event plus the holding level.
    typedef struct packed {
        logic press;
        logic rel;
        logic click;
        logic dbl;
        logic long_press;
        logic holding;
    } btn_evt_t;

endpackage : btn_evt_pkg

// File: rtl/level_edge_det.sv
// Registers a synchronous level and reports its rising and falling edges.
module level_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_c_o = level_i & ~level_q;
    assign fall_c_o = ~level_i & level_q;

endmodule : level_edge_det

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/double-click/long-press pulses.
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter int unsigned DOUBLE_CLICK_GAP  = DOUBLE_CLICK_GAP_DEF,
    parameter int unsigned CNT_W             = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic holding
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_CLICK_GAP - 1);

    logic             rise;
    logic             fall;
    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    btn_evt_t         evt_q;
    btn_evt_t         evt_d;
    logic             long_hit;
    logic             gap_hit;

    level_edge_det u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .level_i  (btn_level),
        .rise_c_o (rise),
        .fall_c_o (fall)
    );

    assign long_hit = (timer_q == LONG_LAST);
    assign gap_hit  = (timer_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            evt_q   <= evt_d;
        end
    end

    // Edges take priority over timeouts in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESSED;
            end
            PRESSED: begin
                if (fall)          state_d = WAIT_SECOND;
                else if (long_hit) state_d = LONG_HELD;
            end
            LONG_HELD: begin
                if (fall) state_d = IDLE;
            end
            WAIT_SECOND: begin
                if (rise)         state_d = SECOND_PRESSED;
                else if (gap_hit) state_d = IDLE;
            end
            SECOND_PRESSED: begin
                if (fall)          state_d = IDLE;
                else if (long_hit) state_d = LONG_HELD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        evt_d   = '0;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                evt_d.press = rise;
            end
            PRESSED: begin
                evt_d.rel        = fall;
                evt_d.long_press = ~fall & long_hit;
            end
            LONG_HELD: begin
                evt_d.rel = fall;
            end
            WAIT_SECOND: begin
                evt_d.press = rise;
                evt_d.click = ~rise & gap_hit;
            end
            SECOND_PRESSED: begin
                evt_d.rel        = fall;
                evt_d.dbl        = fall;
                evt_d.long_press = ~fall & long_hit;
            end
            default: ;
        endcase
        evt_d.holding = (state_d == LONG_HELD);
        // Timer restarts on every state change and only runs in the timed states.
        if ((state_d == state_q) &&
            ((state_q == PRESSED) || (state_q == WAIT_SECOND) || (state_q == SECOND_PRESSED))) begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    assign press_pulse   = evt_q.press;
    assign release_pulse = evt_q.rel;
    assign click         = evt_q.click;
    assign double_click  = evt_q.dbl;
    assign long_press    = evt_q.long_press;
    assign holding       = evt_q.holding;

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// Randomized and directed bench for button_event_decoder against a timestamp-based model.
module tb_button_event_decoder;

    localparam int LPC = 20;
    localparam int DCG = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_level = 1'b0;
    logic press_pulse, release_pulse, click, double_click, long_press, holding;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_PRESS_CYCLES (LPC),
        .DOUBLE_CLICK_GAP  (DCG),
        .CNT_W             (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click         (click),
        .double_click  (double_click),
        .long_press    (long_press),
        .holding       (holding)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: timestamps of the last accepted press/release plus a coarse phase.
    bit m_prev, m_long, m_second;
    int m_phase;      // 0 = no activity, 1 = button down, 2 = waiting for second press
    int m_press_at, m_release_at;
    bit e_press, e_rel, e_click, e_dbl, e_long, e_hold;

    int t_press, t_rel, t_click, t_dbl, t_long;
    int n_press, n_rel, n_click, n_dbl, n_long, n_hold;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b0; m_long = 1'b0; m_second = 1'b0; m_phase = 0;
        e_press = 1'b0; e_rel = 1'b0; e_click = 1'b0; e_dbl = 1'b0; e_long = 1'b0; e_hold = 1'b0;
    endtask

    task automatic model_step(input bit lvl, input int k);
        bit rise, fall;
        rise = lvl && !m_prev;
        fall = !lvl && m_prev;
        m_prev = lvl;
        e_press = 1'b0; e_rel = 1'b0; e_click = 1'b0; e_dbl = 1'b0; e_long = 1'b0;
        if (m_phase == 0) begin
            if (rise) begin
                m_phase = 1; m_press_at = k; m_second = 1'b0; m_long = 1'b0; e_press = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (fall) begin
                e_rel = 1'b1;
                if (m_long) m_phase = 0;
                else if (m_second) begin e_dbl = 1'b1; m_phase = 0; end
                else begin m_phase = 2; m_release_at = k; end
            end else if (!m_long && (k - m_press_at == LPC)) begin
                m_long = 1'b1; e_long = 1'b1;
            end
        end else begin
            if (rise) begin
                m_phase = 1; m_second = 1'b1; m_press_at = k; e_press = 1'b1;
            end else if (k - m_release_at == DCG) begin
                e_click = 1'b1; m_phase = 0;
            end
        end
        e_hold = (m_phase == 1) && m_long;
    endtask

    task automatic clr_log();
        t_press = -1000; t_rel = -1000; t_click = -1000; t_dbl = -1000; t_long = -1000;
        n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0; n_hold = 0;
    endtask

    // Single compare process: DUT vs model on every falling edge, plus event logging.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("press_pulse",   press_pulse,   e_press);
                check("release_pulse", release_pulse, e_rel);
                check("click",         click,         e_click);
                check("double_click",  double_click,  e_dbl);
                check("long_press",    long_press,    e_long);
                check("holding",       holding,       e_hold);
                if (press_pulse === 1'b1)   begin n_press++; t_press = cyc; end
                if (release_pulse === 1'b1) begin n_rel++;   t_rel   = cyc; end
                if (click === 1'b1)         begin n_click++; t_click = cyc; end
                if (double_click === 1'b1)  begin n_dbl++;   t_dbl   = cyc; end
                if (long_press === 1'b1)    begin n_long++;  t_long  = cyc; end
                if (holding === 1'b1)       n_hold++;
            end
        end
    end

    task automatic tick(input bit lvl);
        btn_level = lvl;
        @(posedge clk);
        cyc++;
        if (rst_n) model_step(lvl, cyc);
        else       model_reset();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit lvl);
        btn_level = lvl;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_press",   press_pulse,   0);
        check("rst_async_release", release_pulse, 0);
        check("rst_async_click",   click,         0);
        check("rst_async_dbl",     double_click,  0);
        check("rst_async_long",    long_press,    0);
        check("rst_async_holding", holding,       0);
        repeat (2) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        bit lvl;
        model_reset();
        clr_log();
        repeat (2) @(negedge clk);
        check("reset_press",   press_pulse,   0);
        check("reset_holding", holding,       0);
        check("reset_click",   click,         0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick(1'b0);

        // Single click
        clr_log(); e0 = cyc + 1;
        repeat (5) tick(1'b1);
        repeat (15) tick(1'b0);
        check("sc_press_at",  t_press, e0);
        check("sc_rel_gap",   t_rel - t_press, 5);
        check("sc_click_gap", t_click - t_rel, 10);
        check("sc_n_click",   n_click, 1);
        check("sc_n_dbl",     n_dbl, 0);
        check("sc_n_long",    n_long, 0);

        // Double click
        clr_log();
        repeat (4) tick(1'b1); repeat (3) tick(1'b0);
        repeat (4) tick(1'b1); repeat (15) tick(1'b0);
        check("dc_n_press", n_press, 2);
        check("dc_n_dbl",   n_dbl, 1);
        check("dc_same_cy", t_dbl - t_rel, 0);
        check("dc_n_click", n_click, 0);

        // Long press
        clr_log();
        repeat (30) tick(1'b1); repeat (15) tick(1'b0);
        check("lp_gap",     t_long - t_press, 20);
        check("lp_n_hold",  n_hold, 10);
        check("lp_n_rel",   n_rel, 1);
        check("lp_n_click", n_click, 0);

        // Release exactly when the hold timer reads LPC-1
        clr_log();
        repeat (20) tick(1'b1); repeat (15) tick(1'b0);
        check("bp_n_long",    n_long, 0);
        check("bp_rel_gap",   t_rel - t_press, 20);
        check("bp_click_gap", t_click - t_rel, 10);

        // Second rise exactly when the gap timer reads DCG-1
        clr_log();
        repeat (4) tick(1'b1); repeat (10) tick(1'b0);
        repeat (4) tick(1'b1); repeat (15) tick(1'b0);
        check("bg_n_dbl",   n_dbl, 1);
        check("bg_n_click", n_click, 0);
        check("bg_n_press", n_press, 2);

        // Reset during the double-click gap loses the pending click
        repeat (4) tick(1'b1); repeat (3) tick(1'b0);
        clr_log();
        do_reset(1'b0);
        repeat (15) tick(1'b0);
        check("rw_n_click", n_click, 0);

        // Button held through reset yields a press on the first active cycle
        repeat (4) tick(1'b1); repeat (3) tick(1'b0);
        do_reset(1'b1);
        clr_log(); e0 = cyc + 1;
        tick(1'b1);
        check("rh_press_at", t_press, e0);
        repeat (3) tick(1'b1); repeat (15) tick(1'b0);

        // Random segments biased toward the timing boundaries
        lvl = 1'b0;
        for (int s = 0; s < 250; s++) begin
            int len, r;
            if ($urandom_range(0, 29) == 0) do_reset(1'($urandom_range(0, 1)));
            lvl = ~lvl;
            r = int'($urandom_range(0, 9));
            if (r < 3)      len = int'($urandom_range(1, 5));
            else if (r < 6) len = int'($urandom_range(8, 12));
            else            len = int'($urandom_range(18, 24));
            repeat (len) tick(lvl);
        end
        repeat (30) tick(1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_event_decoder
